// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: frame width, FSM encodings
// and a constant log2 helper used to size the bit-period divider.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fc_sync_fifo.sv
// Small circular-buffer FIFO with an explicit occupancy counter.
// A pop frees a slot in the same cycle, so push+pop while full is accepted.
module sync_fifo #(
  parameter int FIFO_ADDR_BITS = 2,
  parameter int DATA_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_W-1:0]       din,
  input  logic                    pop,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [FIFO_ADDR_BITS:0] level
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [FIFO_ADDR_BITS:0] DEPTH_L = (FIFO_ADDR_BITS+1)'(DEPTH);

  logic [DATA_W-1:0]         mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr;
  logic                      pop_ok;
  logic                      push_ok;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fc.sv
// 8N1 UART receiver with FIFO buffering and RTS flow control; samples at
// mid-bit off a free-running divider restarted at each start edge.
module uart_rx_fc
  import uart_pkg::*;
#(
  parameter int CLK_DIV        = 104,
  parameter int FIFO_ADDR_BITS = 2,
  parameter int RTS_MARGIN     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx,
  output logic                    rts,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_err,
  output logic                    overrun,
  output logic [FIFO_ADDR_BITS:0] level
);

  localparam int DIV_W = clog2(CLK_DIV);
  localparam int IDX_W = clog2(DATA_BITS);
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;

  logic                    rx_m;
  logic                    rx_s;
  logic [2:0]              state;
  logic [DIV_W-1:0]        div;
  logic [IDX_W-1:0]        bit_idx;
  logic [DATA_BITS-1:0]    shreg;
  logic                    tick;
  logic                    stop_sample;
  logic                    push;
  logic                    full;
  logic                    empty;
  logic                    pop_ok;
  logic                    push_ok;
  logic [FIFO_ADDR_BITS:0] level_next;

  // rx is asynchronous; both stages idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick        = (div == '0);
  assign stop_sample = (state == STOP) && tick;
  assign push        = stop_sample & rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            div   <= DIV_W'(CLK_DIV/2 - 1);
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              div     <= DIV_W'(CLK_DIV - 1);
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            div <= div - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shreg[bit_idx] <= rx_s;
            div            <= DIV_W'(CLK_DIV - 1);
            if (bit_idx == IDX_W'(DATA_BITS - 1)) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            div <= div - 1'b1;
          end
        end
        STOP: begin
          if (tick) state <= rx_s ? IDLE : WAIT_IDLE;
          else div <= div - 1'b1;
        end
        WAIT_IDLE: begin
          // Hold off until the line recovers so a break is not read as 0x00 bytes.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .FIFO_ADDR_BITS(FIFO_ADDR_BITS),
    .DATA_W        (DATA_BITS)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (shreg),
    .pop  (out_ready),
    .dout (out_data),
    .full (full),
    .empty(empty),
    .level(level)
  );

  assign out_valid = ~empty;
  assign pop_ok    = out_ready & ~empty;
  assign push_ok   = push & (~full | pop_ok);

  always_comb begin
    level_next = level;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // rts tracks the occupancy the FIFO is about to have, so it moves with level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rts       <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rts       <= (DEPTH - int'(level_next)) > RTS_MARGIN;
      frame_err <= stop_sample & ~rx_s;
      overrun   <= push & full & ~pop_ok;
    end
  end

endmodule

// File: doc/uart_rx_fc.md
Name: uart_rx_fc

Overview:
- UART receiver with hardware flow control: 8N1, LSB first.
- Deserializes the serial `rx` line into bytes, buffers them in a small FIFO, and presents them on a valid/ready stream.
- Drives `rts` so that a peer transmitter honouring CTS stops before the buffer overflows.
- Sits on the host/peer-facing side of the SoC UART: it is the receive end for the design's `tx`/`cts` pair, and is also used as the bench-side monitor.

Parameters:
- CLK_DIV, 104, clock cycles per bit period; legal range is 4 or more.
- FIFO_ADDR_BITS, 2, FIFO depth is 2**FIFO_ADDR_BITS entries.
- RTS_MARGIN, 1, `rts` is deasserted when free entries are RTS_MARGIN or fewer; legal range is 1 to depth-1.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- rts  out  1  1 = peer may send; 0 = peer must stop after the current frame.
- out_data  out  8  head-of-FIFO byte; valid only while out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts; a pop occurs when out_valid & out_ready.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- level  out  FIFO_ADDR_BITS+1  current FIFO occupancy, 0..depth.

Behaviour:
- Synchronizer:
  - `rx` passes through a 2-flop synchronizer giving `rx_s`.
  - Both flops reset to 1.
  - Every timing figure below refers to `rx_s`.
- Reset values:
  - rts=1, out_valid=0, out_data=0, frame_err=0, overrun=0, level=0.
  - FSM=IDLE, bit counter=0, divider=0.
- Reset mid-operation: a reset asserted mid-frame discards the partial byte and all FIFO contents. There is no other recovery path.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: when rx_s=0 (start edge), load the divider with CLK_DIV/2-1 and go to START.
  - START: when the divider reaches 0, sample rx_s.
    - If rx_s=1, treat it as a glitch and return to IDLE.
    - If rx_s=0, reload the divider with CLK_DIV-1, set bit index to 0, and go to DATA.
  - DATA: each divider expiry shifts rx_s into bit[index], LSB first, and reloads the divider with CLK_DIV-1. After index 7, go to STOP.
  - STOP: on divider expiry, sample rx_s.
    - If rx_s=1: push the byte into the FIFO (or pulse overrun if the FIFO is full), then go to IDLE.
    - If rx_s=0: pulse frame_err, drop the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 bytes.
- Sampling points: samples occur at mid-bit, CLK_DIV/2 after the start edge and then every CLK_DIV cycles.
- Push timing: the push happens on the same cycle the stop bit is sampled. out_valid and level update on the next cycle (1-cycle write-to-read latency).
- FIFO:
  - Circular buffer with read/write pointers of FIFO_ADDR_BITS bits that wrap modulo depth.
  - Separate occupancy counter, `level`.
  - out_data is the registered/array read of the head entry and is stable while out_valid=1 and no pop occurs.
- Simultaneous push and pop:
  - When not full: both are performed and level is unchanged.
  - When full: the pop frees a slot in the same cycle, so the push is accepted and overrun does not fire.
- Pop when empty: ignored.
- Push when full with no pop: the byte is dropped, overrun pulses, and level stays at depth.
- rts: registered; rts = (depth - level_next) > RTS_MARGIN, so it changes on the same cycle as level.
- frame_err and overrun: never both pulse in the same cycle. Neither changes the FSM path beyond what is stated above.

Decomposition:
- Package uart_pkg:
  - DATA_BITS=8.
  - FSM state enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - Function clog2 for divider width (divider width = clog2(CLK_DIV)).
- One natural sub-module: sync_fifo (parameter FIFO_ADDR_BITS).
  - Ports: push/din, pop/dout, full, empty, level.
  - Reused by the transmit path.

Test Plan (CLK_DIV=8, FIFO_ADDR_BITS=2, RTS_MARGIN=1):
- Reset, then frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with out_ready=1 -> out_valid rises 1 cycle after the stop-bit sample, out_data=0xA5, level returns to 0, frame_err=0 and overrun=0 throughout.
- rx low pulse of 3 cycles, then high -> FSM returns to IDLE from START, with no push and no error pulses.
- Frame 0x3C with the stop bit held low for 20 cycles, then high -> a single frame_err pulse, no FIFO write, and no additional byte decoded until rx returns high and a new start edge arrives.
- out_ready=0 with 0x01..0x05 sent back-to-back:
  - rts falls when level becomes 3.
  - level saturates at 4.
  - The 5th byte causes an overrun pulse.
  - With out_ready then set to 1, reads return 0x01, 0x02, 0x03, 0x04 in order, and rts rises when level drops to 2.
- With the FIFO full, time out_ready=1 so the pop coincides with the stop-bit push of 0x77 -> no overrun, level stays 4, and 0x77 is read last.
- Assert reset during DATA bit 4 of a frame with 2 bytes already buffered -> level=0, out_valid=0, rts=1 the cycle after reset, and the next clean frame 0x5A is received correctly.
